// File: rtl/gray_counter_modn.sv
// Modulo-MOD cyclic Gray-code counter with up/down, enable and synchronous load.
// The reflected-Gray index offset makes the truncated code sequence cyclic.
module gray_counter_modn #(
  parameter int MOD   = 6,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] bin,
  output logic             wrap,
  output logic             load_err
);

  localparam int OFFSET = (2**WIDTH - MOD) / 2;
  localparam logic [WIDTH:0] MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0] TOP_EXT = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH:0] OFF_EXT = (WIDTH+1)'(OFFSET);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  if (((MOD & 1) != 0) || (MOD < 2) || (MOD > 2**WIDTH)) begin : g_param_err
    $error("gray_counter_modn: MOD=%0d must be even and within 2..2**WIDTH (WIDTH=%0d)",
           MOD, WIDTH);
  end

  // idx+OFFSET stays below 2**WIDTH, so the extra bit only guards the addition.
  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH:0] i);
    logic [WIDTH:0] x;
    x = i + OFF_EXT;
    return x[WIDTH-1:0] ^ x[WIDTH:1];
  endfunction

  logic [WIDTH:0] idx;
  logic [WIDTH:0] lv_ext;
  logic [WIDTH:0] next_idx;
  logic           next_wrap;
  logic           next_err;

  assign idx    = {1'b0, bin};
  assign lv_ext = {1'b0, load_val};

  always_comb begin
    next_idx  = idx;
    next_wrap = 1'b0;
    next_err  = 1'b0;
    if (load) begin
      if (lv_ext < MOD_EXT) begin
        next_idx = lv_ext;
      end else begin
        next_err = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (idx == TOP_EXT) begin
          next_idx  = '0;
          next_wrap = 1'b1;
        end else begin
          next_idx = idx + ONE_EXT;
        end
      end else begin
        if (idx == '0) begin
          next_idx  = TOP_EXT;
          next_wrap = 1'b1;
        end else begin
          next_idx = idx - ONE_EXT;
        end
      end
    end
  end

  // q is registered from the next index rather than decoded from bin.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bin      <= '0;
      q        <= to_gray('0);
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      bin      <= next_idx[WIDTH-1:0];
      q        <= to_gray(next_idx);
      wrap     <= next_wrap;
      load_err <= next_err;
    end
  end

endmodule

// File: tb/tb_gray_counter_modn.sv
// Scoreboard bench for gray_counter_modn: three instances (MOD 6/10/16),
// driver pushes modelled expectations, monitor pops and compares.
module tb_gray_counter_modn;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst, en, up, load;
  logic [3:0] lv [3];
  logic [2:0] q0, b0;
  logic [3:0] q1, b1, q2, b2;
  logic [2:0] wr, er;

  gray_counter_modn #(.MOD(6), .WIDTH(3)) u0 (
    .clk(clk), .rst(rst[0]), .en(en[0]), .up(up[0]), .load(load[0]),
    .load_val(lv[0][2:0]), .q(q0), .bin(b0), .wrap(wr[0]), .load_err(er[0]));
  gray_counter_modn #(.MOD(10), .WIDTH(4)) u1 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .up(up[1]), .load(load[1]),
    .load_val(lv[1]), .q(q1), .bin(b1), .wrap(wr[1]), .load_err(er[1]));
  gray_counter_modn #(.MOD(16), .WIDTH(4)) u2 (
    .clk(clk), .rst(rst[2]), .en(en[2]), .up(up[2]), .load(load[2]),
    .load_val(lv[2]), .q(q2), .bin(b2), .wrap(wr[2]), .load_err(er[2]));

  typedef struct {
    int   k;
    int   q;
    int   bin;
    bit   wrap;
    bit   err;
    bit   step;
    bit   up;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   mods [3] = '{6, 10, 16};
  int   wids [3] = '{3, 4, 4};
  int   offs [3];
  int   midx [3];
  int   prevq [3];
  int   wraps_up = 0;
  int   wraps_dn = 0;

  function automatic int gray(input int x);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int k, input bit r, input bit e, input bit u,
                       input bit l, input int v);
    exp_t x;
    logic [3:0] v4;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; up[i] = 1'b0; load[i] = 1'b0;
    end
    v4 = 4'(v);
    rst[k] = r; en[k] = e; up[k] = u; load[k] = l; lv[k] = v4;
    x.k = k; x.wrap = 1'b0; x.err = 1'b0; x.step = 1'b0; x.up = u;
    if (!r) begin
      midx[k] = 0;
    end else if (l) begin
      if (v < mods[k]) midx[k] = v;
      else x.err = 1'b1;
    end else if (e) begin
      x.step = 1'b1;
      if (u) begin
        x.wrap  = (midx[k] + 1 == mods[k]);
        midx[k] = (midx[k] + 1) % mods[k];
      end else begin
        x.wrap  = (midx[k] == 0);
        midx[k] = (midx[k] + mods[k] - 1) % mods[k];
      end
    end
    x.bin = midx[k];
    x.q   = gray(midx[k] + offs[k]);
    sbq.push_back(x);
  endtask

  // Monitor: samples one time unit after each rising edge.
  initial begin
    exp_t e;
    int aq, ab, aw, ae;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        case (e.k)
          0:       begin aq = int'(q0); ab = int'(b0); end
          1:       begin aq = int'(q1); ab = int'(b1); end
          default: begin aq = int'(q2); ab = int'(b2); end
        endcase
        aw = int'(wr[e.k]);
        ae = int'(er[e.k]);
        chk($sformatf("q[%0d]", e.k), aq, e.q);
        chk($sformatf("bin[%0d]", e.k), ab, e.bin);
        chk($sformatf("wrap[%0d]", e.k), aw, int'(e.wrap));
        chk($sformatf("load_err[%0d]", e.k), ae, int'(e.err));
        if (e.step)
          chk($sformatf("one_bit_step[%0d]", e.k), $countones(aq ^ prevq[e.k]), 1);
        if (e.k == 1 && aw == 1) begin
          if (e.up) wraps_up++;
          else      wraps_dn++;
        end
        prevq[e.k] = aq;
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      offs[i]  = ((1 << wids[i]) - mods[i]) / 2;
      midx[i]  = 0;
      prevq[i] = 0;
      rst[i] = 1'b0; en[i] = 1'b0; up[i] = 1'b0; load[i] = 1'b0; lv[i] = '0;
    end
    repeat (2) @(negedge clk);

    // Six-state instance: reset, full up cycle with wrap
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    repeat (7) drive(0, 1, 1, 1, 0, 0);
    // down from reset through the 0->5 wrap
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    repeat (2) drive(0, 1, 1, 0, 0, 0);
    // load in range with en high, then out of range, then hold
    drive(0, 1, 1, 1, 1, 4);
    drive(0, 1, 1, 1, 1, 7);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 1, 6);
    drive(0, 1, 0, 1, 0, 0);
    // reset while counting at bin=3, then resume
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 1, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    repeat (2) drive(0, 1, 1, 1, 0, 0);
    // random traffic including out-of-range loads
    repeat (300)
      drive(0, $urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
            1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7));

    // Ten-state instance: free-run up then down
    repeat (2) drive(1, 0, 0, 0, 0, 0);
    repeat (25) drive(1, 1, 1, 1, 0, 0);
    repeat (25) drive(1, 1, 1, 0, 0, 0);

    // Sixteen-state instance: plain reflected Gray, random stimulus
    repeat (2) drive(2, 0, 0, 0, 0, 0);
    repeat (2000)
      drive(2, $urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
            1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 15));

    for (int t = 0; t < 10 && sbq.size() > 0; t++) @(posedge clk);
    #2;
    chk("scoreboard_drained", sbq.size(), 0);
    chk("mod10_wraps_up", wraps_up, 2);
    chk("mod10_wraps_down", wraps_dn, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
